// File: rtl/io_pkg.sv
// Shared types and constants for the host UART transmit path.
// Build option: define TX_WORD_MODE_EN for 32-bit FIFO entries sent as four
// little-endian bytes; otherwise entries are single bytes.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int unsigned DEFAULT_CLK_PER_BIT = 868;
  localparam int unsigned UART_FRAME_BITS     = 10;
  localparam int unsigned UART_DATA_BITS      = UART_FRAME_BITS - 2;
  localparam int unsigned OUT_DATA_W          = 32;

`ifdef TX_WORD_MODE_EN
  localparam int unsigned BYTES_PER_ENTRY = 4;
`else
  localparam int unsigned BYTES_PER_ENTRY = 1;
`endif

  localparam int unsigned ENTRY_W = 8 * BYTES_PER_ENTRY;

endpackage

// File: rtl/uart_tx_out_if.sv
// Core-to-UART output handshake: payload, write strobe and FIFO-full back-pressure.
interface uart_tx_out_if;
  import io_pkg::*;

  logic [OUT_DATA_W-1:0] output_data;
  logic                  output_valid;
  logic                  output_busy;

  modport master (
    output output_data,
    output output_valid,
    input  output_busy
  );

  modport slave (
    input  output_data,
    input  output_valid,
    output output_busy
  );

endinterface

// File: rtl/tx_fifo.sv
// Output FIFO: power-of-two depth, wrapping pointers, count one bit wider
// than the pointers, registered full flag.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // Qualify requests against occupancy and compute next pointers/count.
  always_comb begin
    do_push = push_i && (count_q != CNT_W'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/uart_tx_out.sv
// Host UART transmitter: buffers core output words and sends them as 8N1
// frames on txd. Build option TX_WORD_MODE_EN sends each 32-bit entry as
// four bytes, low byte first; default sends output_data[7:0] per write.
module uart_tx_out
  import io_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_out_if.slave out_if,
  output logic         txd,
  output logic         tx_idle,
  output logic [7:0]   sdata_debug
);

  localparam int unsigned       BAUD_W    = $clog2(CLK_PER_BIT);
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [ENTRY_W-1:0] word_q, word_d;
  logic               pend_q, pend_d;
  logic               txd_q, txd_d;
  logic               tx_idle_q, tx_idle_d;
  logic [7:0]         sdata_q, sdata_d;
`ifdef TX_WORD_MODE_EN
  logic [1:0]         idx_q, idx_d;
`endif

  logic               push_c, pop_c, start_c, baud_tick_c;
  logic [7:0]         next_byte_c;
  logic [ENTRY_W-1:0] fifo_wdata_c, fifo_rdata_c;
  logic [CNT_W-1:0]   fifo_count, count_nx_c;
  logic               fifo_full;

`ifdef TX_WORD_MODE_EN
  assign fifo_wdata_c = out_if.output_data;
`else
  logic unused_data_hi;
  assign fifo_wdata_c   = out_if.output_data[ENTRY_W-1:0];
  assign unused_data_hi = ^out_if.output_data[OUT_DATA_W-1:ENTRY_W];
`endif

  // Busy is the FIFO's registered full flag, so valid never reaches it combinationally.
  assign push_c             = out_if.output_valid && !out_if.output_busy;
  assign out_if.output_busy = fifo_full;

  tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .wdata_i (fifo_wdata_c),
    .pop_i   (pop_c),
    .rdata_c (fifo_rdata_c),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  assign baud_tick_c = (baud_q == BAUD_LAST);

  // Serializer next-state, byte loader and registered-output values.
  always_comb begin
    state_d     = state_q;
    baud_d      = (state_q == ST_IDLE || baud_tick_c) ? '0 : baud_q + BAUD_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    word_d      = word_q;
    pend_d      = pend_q;
    txd_d       = txd_q;
    sdata_d     = sdata_q;
    pop_c       = 1'b0;
    start_c     = 1'b0;
    next_byte_c = '0;
`ifdef TX_WORD_MODE_EN
    idx_d       = idx_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d      = 1'b0;
          next_byte_c = word_q[7:0];
          start_c     = 1'b1;
`ifdef TX_WORD_MODE_EN
          idx_d       = '0;
`endif
        end else if (fifo_count != '0) begin
          pop_c  = 1'b1;
          word_d = fifo_rdata_c;
          pend_d = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick_c) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick_c) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_tick_c) begin
`ifdef TX_WORD_MODE_EN
          if (idx_q != 2'(BYTES_PER_ENTRY - 1)) begin
            idx_d       = idx_q + 2'd1;
            next_byte_c = 8'(word_q >> {idx_d, 3'b000});
            start_c     = 1'b1;
          end else
`endif
          if (fifo_count != '0) begin
            pop_c       = 1'b1;
            word_d      = fifo_rdata_c;
            next_byte_c = fifo_rdata_c[7:0];
            start_c     = 1'b1;
`ifdef TX_WORD_MODE_EN
            idx_d       = '0;
`endif
          end else begin
            state_d = ST_IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (start_c) begin
      state_d = ST_START;
      baud_d  = '0;
      shift_d = next_byte_c;
      sdata_d = next_byte_c;
      txd_d   = 1'b0;
    end

    count_nx_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    tx_idle_d  = (state_d == ST_IDLE) && (count_nx_c == '0) && !pend_d;
  end

  // Serializer state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      pend_q    <= 1'b0;
      txd_q     <= 1'b1;
      tx_idle_q <= 1'b1;
      sdata_q   <= '0;
`ifdef TX_WORD_MODE_EN
      idx_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      pend_q    <= pend_d;
      txd_q     <= txd_d;
      tx_idle_q <= tx_idle_d;
      sdata_q   <= sdata_d;
`ifdef TX_WORD_MODE_EN
      idx_q     <= idx_d;
`endif
    end
  end

  assign txd         = txd_q;
  assign tx_idle     = tx_idle_q;
  assign sdata_debug = sdata_q;

endmodule
